// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the ALU arbiter slice.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_ADD = 3'b000;
    localparam alu_op_t OP_SUB = 3'b001;
    localparam alu_op_t OP_NOT = 3'b010;
    localparam alu_op_t OP_AND = 3'b011;
    localparam alu_op_t OP_OR  = 3'b100;
    localparam alu_op_t OP_XOR = 3'b101;
    localparam alu_op_t OP_LT  = 3'b110;
    localparam alu_op_t OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: add/sub/logic/compare with zero, overflow and carry flags.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller registers the result.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_t      op,
    output logic [W-1:0] out,
    output logic         zero,
    output logic         overflow,
    output logic         carry
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       add_ovf;
    logic       sub_ovf;
    logic       lt;

    // Carry-out of sum is the add carry; top bit of diff is the unsigned borrow.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    assign sub_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    // Signed less-than: the sign of the difference, corrected when it overflowed.
    assign lt      = diff[W-1] ^ sub_ovf;

    // Select result and arithmetic flags by opcode; logic/compare ops clear the flags.
    always_comb begin
        out      = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                out      = sum[W-1:0];
                carry    = sum[W];
                overflow = add_ovf;
            end
            OP_SUB: begin
                out      = diff[W-1:0];
                carry    = diff[W];
                overflow = sub_ovf;
            end
            OP_NOT:  out = ~a;
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            OP_LT:   out = W'(lt);
            OP_EQ:   out = W'(a == b);
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, IDLE/EXEC/RESP FSM.
// Latency: accept in cycle N, rsp_valid in cycle N+2; one operation in flight, 3-cycle issue interval.
// Backpressure: response held stable until rsp_ready; req_ready stays low while busy.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    input  logic [NREQ*3-1:0]        req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_out,
    output logic                     rsp_zero,
    output logic                     rsp_overflow,
    output logic                     rsp_carry,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);

    typedef struct packed {
        logic [IW-1:0] id;
        alu_op_t       op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
    } op_req_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   last_grant_q;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [IW:0]     cand;
    logic            accept;
    op_req_t         op_q;

    logic [W-1:0]    alu_out;
    logic            alu_zero;
    logic            alu_ovf;
    logic            alu_carry;

    // Round-robin search: first valid requester starting just after the last grant.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (grant == '0 && req_valid[cand[IW-1:0]]) begin
                grant[cand[IW-1:0]] = 1'b1;
                grant_idx           = cand[IW-1:0];
            end
        end
    end

    // Grant is only offered in IDLE and is forced off while reset is held.
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // Next-state and status outputs; the RESP handshake returns to IDLE without accepting.
    always_comb begin
        state_d   = state_q;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Capture the granted requester's operands and advance the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= '0;
            last_grant_q <= IW'(NREQ-1);
        end else if (accept) begin
            op_q.id      <= grant_idx;
            op_q.op      <= req_op[grant_idx*3 +: 3];
            op_q.a       <= req_a[grant_idx*W +: W];
            op_q.b       <= req_b[grant_idx*W +: W];
            last_grant_q <= grant_idx;
        end
    end

    // Register the ALU result during EXEC; it then holds through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id       <= '0;
            rsp_out      <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_carry    <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_id       <= op_q.id;
            rsp_out      <= alu_out;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_ovf;
            rsp_carry    <= alu_carry;
        end
    end

    alu_core #(.W(W)) u_core (
        .a        (op_q.a),
        .b        (op_q.b),
        .op       (op_q.op),
        .out      (alu_out),
        .zero     (alu_zero),
        .overflow (alu_ovf),
        .carry    (alu_carry)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: per-requester operation queues, arithmetic reference model.
// Latency: expects rsp_valid two cycles after each accept.
// Backpressure: rsp_ready randomized or held low to exercise response hold.
module tb_alu_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [W-1:0]      rsp_out;
    logic              rsp_zero;
    logic              rsp_overflow;
    logic              rsp_carry;
    logic              busy;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_out      (rsp_out),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_carry    (rsp_carry),
        .busy         (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        bit           has_exp;
        logic [W-1:0] e_out;
        logic         e_z;
        logic         e_v;
        logic         e_c;
    } op_t;

    typedef struct {
        int           id;
        logic [W-1:0] out;
        logic         z;
        logic         v;
        logic         c;
    } exp_t;

    op_t             slots [NREQ][64];
    int              hd [NREQ];
    int              tl [NREQ];
    exp_t            exp_q [$];
    int              log_id [$];
    int              log_cyc [$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    bit              in_flight;
    int              acc_cyc;
    int              m_last;
    bit [NREQ-1:0]   pop_mask;
    int              rdy_prob;
    int              exp_order [5] = '{0, 1, 2, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic on plain integers, signed views taken as two's complement of W bits.
    function automatic exp_t ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t r;
        int   m;
        int   ia;
        int   ib;
        int   sa;
        int   sb;
        int   res;
        m   = 1 << W;
        ia  = int'(a);
        ib  = int'(b);
        sa  = (ia >= m/2) ? ia - m : ia;
        sb  = (ib >= m/2) ? ib - m : ib;
        r.id = 0;
        r.v = 1'b0;
        r.c = 1'b0;
        res = 0;
        case (op)
            3'd0: begin
                res = ia + ib;
                r.c = (res >= m);
                r.v = ((sa + sb) > (m/2 - 1)) || ((sa + sb) < -(m/2));
            end
            3'd1: begin
                res = ia - ib;
                r.c = (ia < ib);
                r.v = ((sa - sb) > (m/2 - 1)) || ((sa - sb) < -(m/2));
            end
            3'd2: res = m - 1 - ia;
            3'd3: res = ia & ib;
            3'd4: res = ia | ib;
            3'd5: res = ia ^ ib;
            3'd6: res = (sa < sb) ? 1 : 0;
            default: res = (ia == ib) ? 1 : 0;
        endcase
        res   = ((res % m) + m) % m;
        r.out = res[W-1:0];
        r.z   = (res == 0);
        return r;
    endfunction

    task automatic enq(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input bit has_exp, input logic [W-1:0] eo, input logic ez, input logic ev, input logic ec);
        op_t o;
        o.a = a; o.b = b; o.op = op; o.has_exp = has_exp;
        o.e_out = eo; o.e_z = ez; o.e_v = ev; o.e_c = ec;
        slots[i][tl[i] % 64] = o;
        tl[i]++;
    endtask

    task automatic enq_rand(input int i);
        enq(i, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic int pending_ops();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += tl[i] - hd[i];
        return s;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (pop_mask[i]) hd[i]++;
        end
        pop_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (hd[i] < tl[i]) begin
                op_t o;
                o = slots[i][hd[i] % 64];
                req_valid[i]       = 1'b1;
                req_a[i*W +: W]    = o.a;
                req_b[i*W +: W]    = o.b;
                req_op[i*3 +: 3]   = o.op;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        rsp_ready = ($urandom_range(0, 99) < rdy_prob);
    endtask

    // Abstract model: one op in flight, response two cycles after accept, round-robin pick.
    task automatic model_step();
        logic [NREQ-1:0] eg;
        int              pick;
        bit              erv;
        exp_t            e;
        op_t             o;
        if (rst) begin
            chk("reset_outputs",
                32'({rsp_valid, busy, rsp_zero, rsp_overflow, rsp_carry, rsp_out, rsp_id, req_ready}), 32'd0);
            in_flight = 1'b0;
            m_last    = NREQ - 1;
            pop_mask  = '0;
            exp_q.delete();
            return;
        end
        eg   = '0;
        pick = -1;
        if (!in_flight) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (pick < 0 && req_valid[i]) begin
                    pick  = i;
                    eg[i] = 1'b1;
                end
            end
        end
        chk("grant", 32'(req_ready), 32'(eg));
        erv = in_flight && (cyc >= acc_cyc + 2);
        chk("rsp_valid", 32'(rsp_valid), 32'(erv));
        chk("busy", 32'(busy), 32'(in_flight));
        if (|(req_valid & req_ready)) begin
            int id = 0;
            for (int j = 0; j < NREQ; j++) if (req_valid[j] && req_ready[j]) id = j;
            log_id.push_back(id);
            log_cyc.push_back(cyc);
        end
        if (pick >= 0) begin
            o = slots[pick][hd[pick] % 64];
            if (o.has_exp) begin
                e.out = o.e_out; e.z = o.e_z; e.v = o.e_v; e.c = o.e_c;
            end else begin
                e = ref_alu(o.a, o.b, o.op);
            end
            e.id = pick;
            exp_q.push_back(e);
            in_flight      = 1'b1;
            acc_cyc        = cyc;
            m_last         = pick;
            pop_mask[pick] = 1'b1;
        end else if (erv && rsp_ready) begin
            in_flight = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        model_step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pending_ops() > 0 || in_flight) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", 32'(pending_ops() + int'(in_flight)), 32'd0);
    endtask

    // Response monitor: every cycle rsp_valid is high the outputs must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q[0];
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_out", 32'(rsp_out), 32'(e.out));
                chk("rsp_flags", 32'({rsp_zero, rsp_overflow, rsp_carry}), 32'({e.z, e.v, e.c}));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        rdy_prob  = 100;
        in_flight = 1'b0;
        acc_cyc   = 0;
        m_last    = NREQ - 1;
        pop_mask  = '0;
        for (int i = 0; i < NREQ; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end

        repeat (3) cycle();
        rst = 1'b0;

        // Directed ALU vectors on requester 0 with hand-computed results.
        enq(0, 4'd3,  4'd4, 3'b000, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0);
        enq(0, 4'd7,  4'd1, 3'b000, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0);
        enq(0, 4'd15, 4'd1, 3'b000, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1);
        enq(0, 4'd2,  4'd5, 3'b001, 1'b1, 4'hD,  1'b0, 1'b0, 1'b1);
        enq(0, 4'd8,  4'd7, 3'b110, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0);
        enq(0, 4'd9,  4'd9, 3'b111, 1'b1, 4'd1,  1'b0, 1'b0, 1'b0);
        drive();
        drain(100);

        // Response stall: rsp_ready low for several cycles while in RESP.
        rdy_prob = 0;
        enq_rand(1);
        drive();
        n = 0;
        while (!(in_flight && cyc >= acc_cyc + 2) && n < 20) begin
            cycle();
            n++;
        end
        repeat (5) cycle();
        rdy_prob = 100;
        drain(50);

        // Round-robin order from reset with all requesters pending.
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        log_id.delete();
        log_cyc.delete();
        enq_rand(0); enq_rand(0);
        enq_rand(1); enq_rand(1);
        enq_rand(2);
        drive();
        drain(100);
        chk("rr_count", 32'(log_id.size()), 32'd5);
        if (log_id.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("rr_order", 32'(log_id[k]), 32'(exp_order[k]));
                if (k > 0) chk("rr_spacing", 32'(log_cyc[k] - log_cyc[k-1]), 32'd3);
            end
        end

        // Reset during EXEC of a requester-2 operation discards it.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        log_id.delete();
        log_cyc.delete();
        enq_rand(2);
        drive();
        n = 0;
        while (log_id.size() == 0 && n < 10) begin
            cycle();
            n++;
        end
        chk("exec_grant_req2", 32'(log_id.size() > 0 ? log_id[0] : -1), 32'd2);
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        log_id.delete();
        log_cyc.delete();
        enq_rand(0);
        enq_rand(2);
        drive();
        drain(50);
        chk("post_reset_first", 32'(log_id.size() > 0 ? log_id[0] : -1), 32'd0);

        // Randomized traffic with random response backpressure.
        rdy_prob = 60;
        repeat (800) begin
            for (int i = 0; i < NREQ; i++) begin
                if (tl[i] - hd[i] < 4 && $urandom_range(0, 3) == 0) enq_rand(i);
            end
            cycle();
        end
        rdy_prob = 100;
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
